// File: rtl/pipe_trace_buffer_pkg.sv
// rtl/pipe_trace_buffer_pkg.sv - state encodings and entry layout for the trace buffer
// TRACE_TIMESTAMP_EN widens each entry by a 32-bit cycle stamp.
package pipe_trace_buffer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

`ifdef TRACE_TIMESTAMP_EN
  localparam int STAMP_W = 32;
`else
  localparam int STAMP_W = 0;
`endif

  // Entry layout, LSB first: data, rd, pc, then stamp when present.
  function automatic int entry_w(input int xlen, input int ra_w);
    return 2 * xlen + ra_w + STAMP_W;
  endfunction

endpackage

// File: rtl/pipe_trace_buffer_ram.sv
// rtl/pipe_trace_buffer_ram.sv - trace_ram: DEPTH x WIDTH, synchronous write, combinational read
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// rtl/pipe_trace_buffer.sv - circular write-back trace capture with PC/manual trigger and drain port
// TRACE_TIMESTAMP_EN stores a free-running cycle stamp with every entry and drives out_stamp.
module pipe_trace_buffer
  import pipe_trace_buffer_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int RA_W      = 5,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic                     wb_regwrite,
  input  logic [XLEN-1:0]          wb_pc,
  input  logic [RA_W-1:0]          wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     trig_en,
  input  logic [XLEN-1:0]          trig_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [RA_W-1:0]          out_rd,
  output logic [XLEN-1:0]          out_data,
  output logic [31:0]              out_stamp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = entry_w(XLEN, RA_W);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pipe_trace_buffer: DEPTH must be a power of two >= 2");
  end
  if (POST_TRIG < 0 || POST_TRIG >= DEPTH) begin : g_bad_post
    $error("pipe_trace_buffer: POST_TRIG must be in [0, DEPTH)");
  end

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic          overflow_q, overflow_d;
  logic          capture, trigger, ram_we;
  logic [AW-1:0] rptr;
  logic [EW-1:0] ram_wdata, ram_rdata;

  assign capture = wb_valid & wb_regwrite & ((state_q == ST_ARMED) | (state_q == ST_POST));
  assign trigger = (state_q == ST_ARMED) & trig_en & capture & (wb_pc == trig_pc);

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    overflow_d = overflow_q;
    ram_we     = 1'b0;
    if (capture) begin
      ram_we = 1'b1;
      wptr_d = wptr_q + AW'(1);
      if (count_q == CW'(DEPTH)) overflow_d = 1'b1;
      else                       count_d    = count_q + CW'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d    = ST_ARMED;
          wptr_d     = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      ST_ARMED: begin
        // A manual stop outranks a coincident PC match; either way the entry is kept.
        if (stop) begin
          state_d = ST_DONE;
        end else if (trigger) begin
          if (POST_TRIG == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_POST;
            post_cnt_d = AW'(POST_TRIG);
          end
        end
      end
      ST_POST: begin
        if (stop) begin
          state_d = ST_DONE;
        end else if (capture) begin
          post_cnt_d = post_cnt_q - AW'(1);
          if (post_cnt_q == AW'(1)) state_d = ST_DONE;
        end
      end
      default: begin
        if (arm) begin
          state_d    = ST_ARMED;
          wptr_d     = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end else if (out_valid && out_ready) begin
          count_d = count_q - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wptr_q     <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] stamp_q, stamp_d;

  assign stamp_d = stamp_q + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) stamp_q <= '0;
    else       stamp_q <= stamp_d;
  end

  assign ram_wdata = {stamp_q, wb_pc, wb_rd, wb_data};
  assign out_stamp = ram_rdata[EW-1 -: 32];
`else
  assign ram_wdata = {wb_pc, wb_rd, wb_data};
  assign out_stamp = 32'd0;
`endif

  // Oldest surviving entry sits count slots behind the write pointer.
  assign rptr = wptr_q - count_q[AW-1:0];

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wptr_q),
    .wdata (ram_wdata),
    .raddr (rptr),
    .rdata (ram_rdata)
  );

  assign out_data  = ram_rdata[XLEN-1:0];
  assign out_rd    = ram_rdata[XLEN +: RA_W];
  assign out_pc    = ram_rdata[XLEN + RA_W +: XLEN];
  assign out_valid = (state_q == ST_DONE) && (count_q != '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb/tb_pipe_trace_buffer.sv - directed self-checking bench for pipe_trace_buffer (TRACE_TIMESTAMP_EN aware)
module tb_pipe_trace_buffer;

  logic        clk = 1'b0;
  logic        reset, wb_valid, wb_regwrite, arm, stop, trig_en, out_ready;
  logic [63:0] wb_pc, wb_data, trig_pc;
  logic [4:0]  wb_rd;
  logic        out_valid, overflow, done;
  logic [63:0] out_pc, out_data;
  logic [4:0]  out_rd;
  logic [31:0] out_stamp;
  logic [4:0]  count;

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  pipe_trace_buffer #(.XLEN(64), .RA_W(5), .DEPTH(16), .POST_TRIG(8)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
    .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data), .arm(arm), .stop(stop),
    .trig_en(trig_en), .trig_pc(trig_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(out_rd), .out_data(out_data), .out_stamp(out_stamp),
    .count(count), .overflow(overflow), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [63:0] pc);
    wb_valid    = v;
    wb_regwrite = rw;
    wb_pc       = pc;
    wb_rd       = pc[6:2];
    wb_data     = ~pc;
    tick();
    wb_valid    = 1'b0;
    wb_regwrite = 1'b0;
  endtask

  task automatic cap(input logic [63:0] pc);
    drive(1'b1, 1'b1, pc);
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  // Pops n entries expected at PCs first, first+4, ...; rd/data follow from the PC.
  task automatic drain(input string tag, input logic [63:0] first, input int n);
    logic [63:0] pc;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < n; i++) begin
      pc = first + 64'(4 * i);
      chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, "_pc"},    out_pc,   pc);
      if (i == 0) begin
        chk({tag, "_rd"},   {59'd0, out_rd}, {59'd0, pc[6:2]});
        chk({tag, "_data"}, out_data, ~pc);
      end
      tick();
    end
    out_ready = 1'b0;
    #1;
    chk({tag, "_empty_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_empty_count"}, {59'd0, count},     64'd0);
  endtask

  initial begin
    logic [63:0] last_pc;
    logic [31:0] st0, st1;
    reset = 1'b1; wb_valid = 0; wb_regwrite = 0; arm = 0; stop = 0; trig_en = 0;
    out_ready = 0; wb_pc = '0; wb_rd = '0; wb_data = '0; trig_pc = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_count", {59'd0, count},      64'd0);
    chk("rst_done",  {63'd0, done},       64'd0);
    chk("rst_valid", {63'd0, out_valid},  64'd0);
    chk("rst_ovf",   {63'd0, overflow},   64'd0);

    // 1: five captures then manual stop
    pulse_arm();
    for (int i = 0; i < 5; i++) cap(64'(4 * i));
    chk("t1_armed_valid", {63'd0, out_valid}, 64'd0);
    pulse_stop();
    chk("t1_done",  {63'd0, done},     64'd1);
    chk("t1_count", {59'd0, count},    64'd5);
    chk("t1_ovf",   {63'd0, overflow}, 64'd0);
    drain("t1", 64'h0, 5);

    // 2: twenty captures wrap the 16-entry ring
    pulse_arm();
    for (int i = 0; i < 20; i++) cap(64'(4 * i));
    pulse_stop();
    chk("t2_count", {59'd0, count},    64'd16);
    chk("t2_ovf",   {63'd0, overflow}, 64'd1);
    drain("t2", 64'h10, 16);

    // 3: PC trigger at 0x40, eight post-trigger captures end at 0x60
    trig_en = 1'b1; trig_pc = 64'h40;
    pulse_arm();
    last_pc = 64'hdead;
    for (int i = 0; i < 40; i++) begin
      cap(64'(4 * i));
      if (done) begin
        last_pc = 64'(4 * i);
        break;
      end
    end
    chk("t3_last_pc", last_pc, 64'h60);
    cap(64'h64);
    trig_en = 1'b0;
    chk("t3_count", {59'd0, count},    64'd16);
    chk("t3_ovf",   {63'd0, overflow}, 64'd1);
    drain("t3", 64'h24, 16);

    // 4: unqualified write-back cycles are skipped
    pulse_arm();
    cap(64'h100);
    drive(1'b1, 1'b0, 64'h200);
    cap(64'h104);
    drive(1'b0, 1'b1, 64'h200);
    drive(1'b0, 1'b0, 64'h200);
    cap(64'h108);
    pulse_stop();
    chk("t4_count", {59'd0, count}, 64'd3);
    drain("t4", 64'h100, 3);

    // 5: back-pressure holds the head entry stable
    pulse_arm();
    for (int i = 0; i < 4; i++) cap(64'h300 + 64'(4 * i));
    pulse_stop();
    for (int i = 0; i < 3; i++) begin
      chk("t5_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("t5_hold_pc",    out_pc,             64'h300);
      chk("t5_hold_count", {59'd0, count},     64'd4);
      tick();
    end
    drain("t5", 64'h300, 4);
    chk("t5_done_after", {63'd0, done}, 64'd1);
    arm = 1'b1; stop = 1'b1; tick(); arm = 1'b0; stop = 1'b0;
    chk("t5_arm_wins", {63'd0, done}, 64'd0);
    pulse_stop();

    // 6: reset in POST discards the capture
    trig_en = 1'b1; trig_pc = 64'h500;
    pulse_arm();
    cap(64'h500);
    cap(64'h504);
    trig_en = 1'b0;
    chk("t6_post_done", {63'd0, done}, 64'd0);
    reset = 1'b1;
    tick();
    chk("t6_rst_count", {59'd0, count},     64'd0);
    chk("t6_rst_done",  {63'd0, done},      64'd0);
    chk("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    reset = 1'b0;
    pulse_stop();
    chk("t6_idle_stop", {63'd0, done}, 64'd0);

    pulse_arm();
    cap(64'h600);
    cap(64'h604);
    pulse_stop();
    st0 = out_stamp;
    out_ready = 1'b1; tick(); out_ready = 1'b0; #1;
    st1 = out_stamp;
`ifdef TRACE_TIMESTAMP_EN
    chk("t6_stamp_delta", {32'd0, st1 - st0}, 64'd1);
`else
    chk("t6_stamp0", {32'd0, st0}, 64'd0);
    chk("t6_stamp1", {32'd0, st1}, 64'd0);
`endif
    chk("t6_pc1", out_pc, 64'h604);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
